// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered, handshaked ALU placed between register-file read and
//           writeback.
//
// Single-cycle ops (ADD, SUB, CMP, CMPR, AND, OR, XOR, NOT, LSH, RSH, ARSH)
// present their result one cycle after accept. MUL/FMUL use an iterative
// shift-add multiplier, one multiplier bit per cycle, WIDTH cycles in total.
//
// Optional feature macro: ALU_SEQ_DIV_EN
//   defined   -> opcode 13 is an unsigned restoring divider (WIDTH cycles)
//   undefined -> opcode 13 is illegal; no divider state or datapath is built
//
// Parameters
//   WIDTH : operand/result width (>= 4, power of 2)
//   SHW   : shift-amount bits taken from operand A
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands/opcode valid
//   in_ready   : block can accept (only in IDLE)
//   opcode     : operation select (0..15)
//   a, b       : operands
//   out_valid  : result valid (DONE state)
//   out_ready  : consumer accepts result
//   c          : primary result (low product half, quotient)
//   d          : secondary result (high product half, remainder), else 0
//   flag_low   : low flag
//   flag_neg   : negative flag
//   flag_zero  : zero flag
//   flag_carry : carry / borrow / divide-by-zero
//   illegal    : opcode was illegal
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             flag_low,
    output logic             flag_neg,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             illegal
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_CMPR = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_LSH  = 4'd8;
    localparam logic [3:0] OP_RSH  = 4'd9;
    localparam logic [3:0] OP_ARSH = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_FMUL = 4'd12;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'd13;
`endif

    localparam logic [SHW:0] CNT_LOAD = WIDTH[SHW:0];
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
`ifdef ALU_SEQ_DIV_EN
        , S_DIV = 2'd3
`endif
    } state_t;

    state_t state, state_nx;

    // Iterative engine: {hi, lo} is the shifting product (MUL) or the
    // remainder/quotient pair (DIV); mcand is the multiplicand or divisor.
    logic [WIDTH-1:0] hi, lo, mcand;
    logic [SHW:0]     cnt;
    logic             fmul_r;

    logic             is_mul, is_div;
    logic             accept;

    // Single-cycle result path
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH:0]          sum_w, diff_w;
    logic [WIDTH-1:0]        sc_c;
    logic                    sc_low, sc_neg, sc_zero, sc_carry, sc_ill;

    // Multiplier step
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

    // Shifts by A; amounts of WIDTH or more flush the value.
    function automatic logic [WIDTH-1:0] shift_val(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] amt,
                                                   input logic [WIDTH-1:0] val);
        logic             over;
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] res;
        over = |amt[WIDTH-1:SHW];
        sh   = amt[SHW-1:0];
        if (op == OP_ARSH) begin
            if (over) res = {WIDTH{val[WIDTH-1]}};
            else      res = $signed(val) >>> sh;
        end else if (op == OP_LSH) begin
            res = over ? '0 : (val << sh);
        end else begin
            res = over ? '0 : (val >> sh);
        end
        return res;
    endfunction

    assign a_s    = a;
    assign b_s    = b;
    assign is_mul = (opcode == OP_MUL) || (opcode == OP_FMUL);
`ifdef ALU_SEQ_DIV_EN
    assign is_div = (opcode == OP_DIV);
`else
    assign is_div = 1'b0;
`endif
    assign accept = in_valid && in_ready;

    always_comb begin
        sum_w    = {1'b0, a} + {1'b0, b};
        diff_w   = {1'b0, a} - {1'b0, b};
        sc_c     = '0;
        sc_low   = 1'b0;
        sc_neg   = 1'b0;
        sc_zero  = 1'b0;
        sc_carry = 1'b0;
        sc_ill   = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_c     = sum_w[WIDTH-1:0];
                sc_carry = sum_w[WIDTH];
                sc_neg   = sc_c[WIDTH-1];
                sc_low   = a_s < b_s;
                sc_zero  = (sc_c == '0);
            end
            OP_SUB: begin
                sc_c     = diff_w[WIDTH-1:0];
                sc_carry = diff_w[WIDTH];
                sc_neg   = sc_c[WIDTH-1];
                sc_low   = a_s < b_s;
                sc_zero  = (sc_c == '0);
            end
            OP_CMP: begin
                sc_low  = a < b;
                sc_neg  = a_s < b_s;
                sc_zero = (a == b);
            end
            OP_CMPR: begin
                sc_low  = b < a;
                sc_neg  = b_s < a_s;
                sc_zero = (a == b);
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                case (opcode)
                    OP_AND:  sc_c = a & b;
                    OP_OR:   sc_c = a | b;
                    OP_XOR:  sc_c = a ^ b;
                    default: sc_c = ~a;
                endcase
                sc_neg  = sc_c[WIDTH-1];
                sc_low  = a < b;
                sc_zero = (sc_c == '0);
            end
            OP_LSH, OP_RSH, OP_ARSH: begin
                sc_c    = shift_val(opcode, a, b);
                sc_zero = (sc_c == '0);
            end
            OP_MUL, OP_FMUL: begin
                sc_c = '0;
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                sc_c = '0;
            end
`endif
            default: sc_ill = 1'b1;
        endcase
    end

    // One multiplier bit per cycle: conditionally add, then shift right.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    // Restoring divide step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits. A zero divisor always "fits",
    // which naturally yields an all-ones quotient and remainder = A.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

    always_comb begin
        div_shift = {hi, lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand};
        div_hi_nx = div_ge ? (div_shift[WIDTH-1:0] - mcand) : div_shift[WIDTH-1:0];
        div_lo_nx = {lo[WIDTH-2:0], div_ge};
    end
`endif

    // Control FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Control FSM: next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_mul)      state_nx = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                    else if (is_div) state_nx = S_DIV;
`endif
                    else             state_nx = S_DONE;
                end
            end
            S_MUL: begin
                if (cnt == CNT_ONE) state_nx = S_DONE;
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
                if (cnt == CNT_ONE) state_nx = S_DONE;
            end
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi         <= '0;
            lo         <= '0;
            mcand      <= '0;
            cnt        <= '0;
            fmul_r     <= 1'b0;
            c          <= '0;
            d          <= '0;
            flag_low   <= 1'b0;
            flag_neg   <= 1'b0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        fmul_r <= (opcode == OP_FMUL);
                        cnt    <= CNT_LOAD;
                        hi     <= '0;
                        if (is_div) begin
                            lo    <= a;
                            mcand <= b;
                        end else begin
                            lo    <= b;
                            mcand <= a;
                        end
                        if (!is_mul && !is_div) begin
                            c          <= sc_c;
                            d          <= '0;
                            flag_low   <= sc_low;
                            flag_neg   <= sc_neg;
                            flag_zero  <= sc_zero;
                            flag_carry <= sc_carry;
                            illegal    <= sc_ill;
                        end
                    end
                end
                S_MUL: begin
                    hi  <= mul_hi_nx;
                    lo  <= mul_lo_nx;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        c          <= fmul_r ? mul_hi_nx : mul_lo_nx;
                        d          <= fmul_r ? '0 : mul_hi_nx;
                        flag_zero  <= fmul_r ? (mul_hi_nx == '0) : (mul_lo_nx == '0);
                        flag_low   <= 1'b0;
                        flag_neg   <= 1'b0;
                        flag_carry <= 1'b0;
                        illegal    <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    hi  <= div_hi_nx;
                    lo  <= div_lo_nx;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        c          <= div_lo_nx;
                        d          <= div_hi_nx;
                        flag_zero  <= (div_lo_nx == '0);
                        flag_carry <= (mcand == '0);
                        flag_low   <= 1'b0;
                        flag_neg   <= 1'b0;
                        illegal    <= 1'b0;
                    end
                end
`endif
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule
